pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with an optional second (skid) entry.
// SKID=1 registers in_ready; SKID=0 uses a single entry with combinational in_ready.
module pipe_skid_reg #(
  parameter int              WIDTH     = 32,
  parameter bit              SKID      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             out_valid_r;
  logic [1:0]       count_r;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid_r & out_ready;
  assign out_valid  = out_valid_r;
  assign out_data   = main_r;
  assign count      = count_r;

  generate
    if (SKID) begin : g_skid
      logic in_ready_r;

      // in_ready drops only when the next state holds both entries.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_r <= 1'b0;
        end else begin
          in_ready_r <= (state_nxt_s != TWO);
        end
      end

      assign in_ready = in_ready_r;
    end else begin : g_noskid
      assign in_ready = out_ready | ~out_valid_r;
    end
  endgenerate

  // Next-state and storage update; flush wins over every fire and leaves storage intact.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else if (in_fire_s && (SKID == 1'b1)) begin
            state_nxt_s = TWO;
            skid_nxt_s  = in_data;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // State, payload storage and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= EMPTY;
      main_r      <= RESET_VAL;
      skid_r      <= RESET_VAL;
      out_valid_r <= 1'b0;
      count_r     <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
      count_r     <= state_nxt_s;
    end
  end

endmodule
